// File: rtl/fret_cfg_sched.sv
// Shadow/active configuration bank for the fret/strum datapath. Host writes land in a shadow
// bank; a commit request copies the whole bank to the active outputs on the next vsync.
module fret_cfg_sched #(
  parameter int unsigned TIMEOUT_W      = 22,
  parameter int unsigned TIMEOUT_CYCLES = 4000000
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         vsync,
  input  logic         wr_valid,
  output logic         wr_ready,
  input  logic [3:0]   wr_addr,
  input  logic [23:0]  wr_data,
  input  logic         commit_req,
  output logic [383:0] cfg_active,
  output logic [15:0]  dirty,
  output logic         busy,
  output logic         commit_done,
  output logic         timeout_err
);

  typedef enum logic [0:0] {StIdle, StPending} state_e;

  localparam logic [TIMEOUT_W-1:0] CntLast = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMEOUT_W-1:0] CntMax  = '1;

  state_e                state_q, state_d;
  logic [TIMEOUT_W-1:0]  cnt_q, cnt_d;
  logic [15:0][23:0]     shadow_q, shadow_d;
  logic [15:0][23:0]     active_q, active_d;
  logic [15:0]           dirty_q, dirty_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  wr_fire;

  // Gating with RST_N keeps the host from seeing ready while reset is held.
  assign wr_ready    = (state_q == StIdle) & RST_N;
  assign wr_fire     = wr_valid & wr_ready;
  assign busy        = (state_q == StPending);
  assign cfg_active  = active_q;
  assign dirty       = dirty_q;
  assign commit_done = done_q;
  assign timeout_err = err_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    active_d = active_q;
    dirty_d  = dirty_q;
    done_d   = 1'b0;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (wr_fire) begin
          // Timing word keeps only {StrumTime, DelayValue}.
          shadow_d[wr_addr] = (wr_addr == 4'd15) ? {15'd0, wr_data[8:0]} : wr_data;
          dirty_d[wr_addr]  = 1'b1;
        end
        if (commit_req) begin
          if ((dirty_q == 16'd0) && !wr_fire) begin
            done_d = 1'b1;
          end else begin
            state_d = StPending;
            cnt_d   = '0;
            err_d   = 1'b0;
          end
        end
      end
      StPending: begin
        if (cnt_q != CntMax) cnt_d = cnt_q + TIMEOUT_W'(1);
        // vsync takes priority over a coincident timeout.
        if (vsync) begin
          active_d = shadow_q;
          dirty_d  = '0;
          done_d   = 1'b1;
          state_d  = StIdle;
        end else if (cnt_q >= CntLast) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      shadow_q <= '0;
      active_q <= '0;
      dirty_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      dirty_q  <= dirty_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

endmodule
